// File: rtl/fetch_decode.sv
// Instruction fetch/decode stage: owns the PC, fetches over a req/ack handshake into the IR,
// and presents decoded register fields plus a sign-extended immediate to the control FSM.
module fetch_decode #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  input  logic            pc_sel,
  input  logic            branch,
  input  logic            zero,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm
);

  localparam int unsigned ILEN = 32;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [6:0]  OPC_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [ILEN-1:0]   ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   imm_c;

  // State and datapath registers; reset wins over any same-cycle ack or pc_sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem_ack) state_d = S_HOLD;
      S_HOLD:  if (pc_sel)   state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Register updates; imem_req is registered from the next state so it tracks FETCH exactly.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    req_d   = (state_d == S_FETCH);
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (pc_sel) begin
          pc_d    = (branch && zero) ? pc_q + imm_c : pc_q + XLEN'(PC_STEP);
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Immediate generation by opcode; anything not LOAD/STORE/BEQ yields zero.
  always_comb begin
    imm_c = '0;
    unique case (ir_q[6:0])
      OPC_LOAD:  imm_c = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
      OPC_STORE: imm_c = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OPC_BEQ:   imm_c = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      default:   imm_c = '0;
    endcase
  end

  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign opcode      = ir_q[6:0];
  assign rd          = ir_q[11:7];
  assign funct3      = ir_q[14:12];
  assign rs1         = ir_q[19:15];
  assign rs2         = ir_q[24:20];
  assign funct7      = ir_q[31:25];
  assign imm         = imm_c;

endmodule

// File: tb/tb_fetch_decode.sv
// Randomized + directed bench for fetch_decode: two instances (reset PC 0 and 0xFFFFFFFC)
// share stimulus and are compared every cycle against a transaction-level reference model.
module tb_fetch_decode;

  localparam logic [31:0] W_LOAD  = 32'h00A12083;
  localparam logic [31:0] W_STORE = 32'hFE112E23;
  localparam logic [31:0] W_BEQ   = 32'hFE208EE3;
  localparam logic [31:0] W_NOP   = 32'h00000013;

  logic        clk;
  logic        reset, imem_ack, pc_sel, branch, zero;
  logic [31:0] imem_rdata;

  logic [31:0] addr0, pc0, imm0, addr1, pc1, imm1;
  logic        req0, valid0, req1, valid1;
  logic [6:0]  opc0, f70, opc1, f71;
  logic [4:0]  rd0, rs10, rs20, rd1, rs11, rs21;
  logic [2:0]  f30, f31;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 = waiting after reset, 1 = fetching, 2 = holding an instruction.
  int          m_ph[2];
  logic [31:0] m_pc[2];
  logic [31:0] m_ir[2];
  logic        m_valid[2];
  logic [31:0] rpc[2];

  fetch_decode #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) u_dut0 (
    .clk(clk), .reset(reset), .imem_addr(addr0), .imem_req(req0),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc_sel(pc_sel),
    .branch(branch), .zero(zero), .pc(pc0), .instr_valid(valid0),
    .opcode(opc0), .rd(rd0), .funct3(f30), .rs1(rs10), .rs2(rs20),
    .funct7(f70), .imm(imm0)
  );

  fetch_decode #(.XLEN(32), .RESET_PC(32'hFFFFFFFC), .PC_STEP(4)) u_dut1 (
    .clk(clk), .reset(reset), .imem_addr(addr1), .imem_req(req1),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc_sel(pc_sel),
    .branch(branch), .zero(zero), .pc(pc1), .instr_valid(valid1),
    .opcode(opc1), .rd(rd1), .funct3(f31), .rs1(rs11), .rs2(rs21),
    .funct7(f71), .imm(imm1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Immediate from the instruction-set definition: gather the scattered bits, then sign-extend.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [31:0] raw;
    int          n;
    case (w % 128)
      3:  begin raw = w >> 20; n = 12; end
      35: begin raw = ((w >> 25) << 5) | ((w >> 7) % 32); n = 12; end
      99: begin
        raw = ((w >> 31) << 12) | (((w >> 7) % 2) << 11) | (((w >> 25) % 64) << 5) | (((w >> 8) % 16) << 1);
        n = 13;
      end
      default: return 32'h0;
    endcase
    raw = raw % (32'd1 << n);
    if (raw >= (32'd1 << (n - 1))) raw = raw - (32'd1 << n);
    return raw;
  endfunction

  task automatic model_step(input int d);
    if (reset) begin
      m_ph[d] = 0; m_pc[d] = rpc[d]; m_ir[d] = 32'h0; m_valid[d] = 1'b0;
    end else if (m_ph[d] == 0) begin
      m_ph[d] = 1;
    end else if (m_ph[d] == 1) begin
      if (imem_ack) begin m_ir[d] = imem_rdata; m_valid[d] = 1'b1; m_ph[d] = 2; end
    end else if (pc_sel) begin
      m_pc[d] = (branch && zero) ? m_pc[d] + ref_imm(m_ir[d]) : m_pc[d] + 32'd4;
      m_valid[d] = 1'b0;
      m_ph[d] = 1;
    end
  endtask

  task automatic check_dut(input int d, input logic [31:0] p, a, im, input logic rq, v,
                           input logic [6:0] op, f7, input logic [4:0] r_d, r1, r2,
                           input logic [2:0] f3);
    logic [31:0] w;
    w = m_ir[d];
    check($sformatf("d%0d_pc", d), p, m_pc[d]);
    check($sformatf("d%0d_valid", d), 32'(v), 32'(m_valid[d]));
    check($sformatf("d%0d_req", d), 32'(rq), (m_ph[d] == 1) ? 32'd1 : 32'd0);
    if (m_ph[d] == 1) check($sformatf("d%0d_addr", d), a, m_pc[d]);
    check($sformatf("d%0d_opcode", d), 32'(op), w % 128);
    check($sformatf("d%0d_rd", d), 32'(r_d), (w >> 7) % 32);
    check($sformatf("d%0d_funct3", d), 32'(f3), (w >> 12) % 8);
    check($sformatf("d%0d_rs1", d), 32'(r1), (w >> 15) % 32);
    check($sformatf("d%0d_rs2", d), 32'(r2), (w >> 20) % 32);
    check($sformatf("d%0d_funct7", d), 32'(f7), w >> 25);
    check($sformatf("d%0d_imm", d), im, ref_imm(w));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
  task automatic cyc(input logic r, a, input logic [31:0] w, input logic s, b, z);
    reset = r; imem_ack = a; imem_rdata = w; pc_sel = s; branch = b; zero = z;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_dut(0, pc0, addr0, imm0, req0, valid0, opc0, f70, rd0, rs10, rs20, f30);
    check_dut(1, pc1, addr1, imm1, req1, valid1, opc1, f71, rd1, rs11, rs21, f31);
  endtask

  task automatic seq_adv(input logic [31:0] w);
    cyc(1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    rpc[0] = 32'h0;
    rpc[1] = 32'hFFFFFFFC;
    for (int d = 0; d < 2; d++) begin
      m_ph[d] = 0; m_pc[d] = 32'h0; m_ir[d] = 32'h0; m_valid[d] = 1'b0;
    end
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; pc_sel = 1'b0; branch = 1'b0; zero = 1'b0;
    @(negedge clk);

    // Reset, then first fetch request on the second cycle after release.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, W_LOAD, 1'b1, 1'b0, 1'b0);
    check("rst_pc", pc0, 32'h0);
    check("rst_req", 32'(req0), 32'd0);
    check("rst_pc_hi", pc1, 32'hFFFFFFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("first_req", 32'(req0), 32'd1);
    check("first_addr", addr0, 32'h0);

    // LOAD decode and sequential advance; the high-reset instance wraps to 0.
    cyc(1'b0, 1'b1, W_LOAD, 1'b0, 1'b0, 1'b0);
    check("load_valid", 32'(valid0), 32'd1);
    check("load_opc", 32'(opc0), 32'h03);
    check("load_rd", 32'(rd0), 32'd1);
    check("load_rs1", 32'(rs10), 32'd2);
    check("load_imm", imm0, 32'd10);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("adv_pc", pc0, 32'h4);
    check("wrap_pc", pc1, 32'h0);

    // Stalled ack keeps the request up and the IR untouched.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, W_STORE, 1'b0, 1'b0, 1'b0);
      check("stall_req", 32'(req0), 32'd1);
      check("stall_ir", 32'(opc0), 32'h03);
    end
    cyc(1'b0, 1'b1, W_STORE, 1'b0, 1'b0, 1'b0);
    check("store_imm", imm0, 32'hFFFFFFFC);
    check("store_rs1", 32'(rs10), 32'd2);
    check("store_rs2", 32'(rs20), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) seq_adv(W_NOP);
    check("pc_0x20", pc0, 32'h20);

    // BEQ taken, not taken (zero=0), and branch=0 with zero=1.
    cyc(1'b0, 1'b1, W_BEQ, 1'b0, 1'b0, 1'b0);
    check("beq_imm", imm0, 32'hFFFFFFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("beq_taken", pc0, 32'h1C);
    seq_adv(W_NOP);
    cyc(1'b0, 1'b1, W_BEQ, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("beq_not_taken", pc0, 32'h24);
    cyc(1'b0, 1'b1, W_BEQ, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("beq_no_branch", pc0, 32'h28);

    // pc_sel during FETCH and ack during HOLD have no effect.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("sel_in_fetch", pc0, 32'h28);
    cyc(1'b0, 1'b1, W_NOP, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, W_LOAD, 1'b0, 1'b0, 1'b0);
    check("ack_in_hold", 32'(opc0), 32'h13);
    check("ack_in_hold_pc", pc0, 32'h28);

    // Reset coincident with ack discards the word; a late ack after reset is ignored.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, W_LOAD, 1'b0, 1'b0, 1'b0);
    check("rst_ack_ir", 32'(opc0), 32'h0);
    check("rst_ack_req", 32'(req0), 32'd0);
    cyc(1'b0, 1'b1, W_STORE, 1'b0, 1'b0, 1'b0);
    check("late_ack_ir", imm0, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      case ($urandom_range(0, 6))
        0: w = {w[31:7], 7'h03};
        1: w = {w[31:7], 7'h23};
        2: w = {w[31:7], 7'h63};
        3: w = {w[31:7], 7'h33};
        4: w = 32'h0;
        5: w = {w[31:7], 7'h13};
        default: ;
      endcase
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0), w,
          ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
